// File: rtl/dds_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dds_pkg                                                                  |
// | Shared DDS/CORDIC types, inverse-gain constants and the atan table.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package dds_pkg;

  localparam int DDS_PHASE_DW      = 16;
  localparam int DDS_IN_DW         = 16;
  localparam int CORDIC_INV_GAIN   = 79594;
  localparam int CORDIC_INV_GAIN_W = 18;

  typedef logic [DDS_PHASE_DW-1:0]      phase_t;
  typedef logic signed [DDS_IN_DW+1:0]  iq_wide_t;

  // round(atan(2^-idx) / (2*pi) * 2^zw), evaluated at elaboration
  function automatic int cordic_atan(input int idx, input int zw);
    real t;
    real s;
    real a;
    t = 1.0;
    s = 1.0;
    for (int k = 0; k < idx; k++) t = t / 2.0;
    for (int k = 0; k < zw; k++)  s = s * 2.0;
    a = $atan(t) / (2.0 * 3.14159265358979323846) * s;
    return $rtoi(a + 0.5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_vec_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cordic_vec_stage                                                         |
// | One registered vectoring micro-rotation; drives Q toward zero.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cordic_vec_stage #(
  parameter int             W     = 18,
  parameter int             ZW    = 18,
  parameter int             SHIFT = 0,
  parameter logic [ZW-1:0]  ATAN  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [W-1:0]  i_x,
  input  logic signed [W-1:0]  i_y,
  input  logic [ZW-1:0]        i_z,
  input  logic                 i_valid,
  input  logic                 i_zero,
  output logic signed [W-1:0]  o_x,
  output logic signed [W-1:0]  o_y,
  output logic [ZW-1:0]        o_z,
  output logic                 o_valid,
  output logic                 o_zero
);

  logic signed [W-1:0] w_xs;
  logic signed [W-1:0] w_ys;
  logic signed [W-1:0] r_x;
  logic signed [W-1:0] r_y;
  logic [ZW-1:0]       r_z;
  logic                r_valid;
  logic                r_zero;

  assign w_xs = i_x >>> SHIFT;
  assign w_ys = i_y >>> SHIFT;

  always_ff @(posedge clk) begin
    if (!i_y[W-1]) begin
      r_x <= i_x + w_ys;
      r_y <= i_y - w_xs;
      r_z <= i_z + ATAN;
    end else begin
      r_x <= i_x - w_ys;
      r_y <= i_y + w_xs;
      r_z <= i_z - ATAN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_zero  <= i_zero;
    end
  end

  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_z     = r_z;
  assign o_valid = r_valid;
  assign o_zero  = r_zero;

endmodule
`default_nettype wire

// File: rtl/iq_to_phase.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iq_to_phase                                                              |
// | Pipelined vectoring-CORDIC I/Q to phase detector, DDS phase convention.  |
// | IQ_TO_PHASE_MAG_EN enables the gain-compensated magnitude output.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module iq_to_phase
  import dds_pkg::*;
#(
  parameter int IN_DW      = DDS_IN_DW,
  parameter int PHASE_DW   = DDS_PHASE_DW,
  parameter int ITERATIONS = 14,
  parameter int GUARD_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2*IN_DW-1:0]    s_axis_in_tdata,
  input  logic                  s_axis_in_tvalid,
  output logic [PHASE_DW-1:0]   m_axis_phase_tdata,
  output logic                  m_axis_phase_tvalid,
  output logic [IN_DW:0]        m_axis_mag_tdata,
  output logic                  m_axis_mag_tvalid
);

  localparam int              c_w     = IN_DW + 2;
  localparam int              c_zw    = PHASE_DW + GUARD_BITS;
  localparam logic [c_zw-1:0] c_half  = c_zw'(1) << (c_zw - 1);
  localparam logic [c_zw-1:0] c_round = (c_zw'(1) << GUARD_BITS) >> 1;

  logic signed [c_w-1:0] r_in_x;
  logic signed [c_w-1:0] r_in_y;
  logic                  r_in_valid;
  logic                  r_in_zero;
  logic signed [c_w-1:0] r_pre_x;
  logic signed [c_w-1:0] r_pre_y;
  logic [c_zw-1:0]       r_pre_z;
  logic                  r_pre_valid;
  logic                  r_pre_zero;

  logic signed [c_w-1:0] w_x     [0:ITERATIONS];
  logic signed [c_w-1:0] w_y     [0:ITERATIONS];
  logic [c_zw-1:0]       w_z     [0:ITERATIONS];
  logic                  w_valid [0:ITERATIONS];
  logic                  w_zero  [0:ITERATIONS];

  logic [PHASE_DW-1:0]   r_phase;
  logic                  r_phase_valid;

  // Free-running data path; only valid and the zero flag are reset.
  always_ff @(posedge clk) begin
    r_in_x <= c_w'($signed(s_axis_in_tdata[IN_DW-1:0]));
    r_in_y <= c_w'($signed(s_axis_in_tdata[2*IN_DW-1:IN_DW]));
    if (r_in_x[c_w-1]) begin
      r_pre_x <= -r_in_x;
      r_pre_y <= -r_in_y;
      r_pre_z <= c_half;
    end else begin
      r_pre_x <= r_in_x;
      r_pre_y <= r_in_y;
      r_pre_z <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_in_valid  <= 1'b0;
      r_in_zero   <= 1'b0;
      r_pre_valid <= 1'b0;
      r_pre_zero  <= 1'b0;
    end else begin
      r_in_valid  <= s_axis_in_tvalid;
      r_in_zero   <= (s_axis_in_tdata == '0);
      r_pre_valid <= r_in_valid;
      r_pre_zero  <= r_in_zero;
    end
  end

  assign w_x[0]     = r_pre_x;
  assign w_y[0]     = r_pre_y;
  assign w_z[0]     = r_pre_z;
  assign w_valid[0] = r_pre_valid;
  assign w_zero[0]  = r_pre_zero;

  for (genvar k = 0; k < ITERATIONS; k++) begin : g_stage
    cordic_vec_stage #(
      .W     (c_w),
      .ZW    (c_zw),
      .SHIFT (k),
      .ATAN  (c_zw'(cordic_atan(k, c_zw)))
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .i_x     (w_x[k]),
      .i_y     (w_y[k]),
      .i_z     (w_z[k]),
      .i_valid (w_valid[k]),
      .i_zero  (w_zero[k]),
      .o_x     (w_x[k+1]),
      .o_y     (w_y[k+1]),
      .o_z     (w_z[k+1]),
      .o_valid (w_valid[k+1]),
      .o_zero  (w_zero[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
    end else begin
      r_phase_valid <= w_valid[ITERATIONS];
      r_phase       <= w_zero[ITERATIONS] ? '0
                     : PHASE_DW'((w_z[ITERATIONS] + c_round) >> GUARD_BITS);
    end
  end

  assign m_axis_phase_tdata  = r_phase;
  assign m_axis_phase_tvalid = r_phase_valid;

`ifdef IQ_TO_PHASE_MAG_EN
  localparam int c_pw = c_w + CORDIC_INV_GAIN_W;
  localparam int c_fb = CORDIC_INV_GAIN_W - 1;

  logic signed [c_pw-1:0] w_mag_prod;
  logic signed [c_pw-1:0] w_mag_sh;
  logic [IN_DW:0]         w_mag_sat;
  logic [IN_DW:0]         r_mag;

  // Inverse CORDIC gain is Q0.17; round to nearest then saturate.
  assign w_mag_prod = c_pw'(w_x[ITERATIONS]) * c_pw'(CORDIC_INV_GAIN);
  assign w_mag_sh   = (w_mag_prod + (c_pw'(1) <<< (c_fb - 1))) >>> c_fb;

  always_comb begin
    w_mag_sat = w_mag_sh[IN_DW:0];
    if (w_mag_sh[c_pw-1]) begin
      w_mag_sat = '0;
    end else if (|w_mag_sh[c_pw-2:IN_DW+1]) begin
      w_mag_sat = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mag <= '0;
    end else begin
      r_mag <= w_zero[ITERATIONS] ? '0 : w_mag_sat;
    end
  end

  assign m_axis_mag_tdata  = r_mag;
  assign m_axis_mag_tvalid = r_phase_valid;
`else
  assign m_axis_mag_tdata  = '0;
  assign m_axis_mag_tvalid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iq_to_phase.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iq_to_phase                                                           |
// | Directed-vector bench for iq_to_phase with an in-order expected queue.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_iq_to_phase;
  import dds_pkg::*;

  localparam int c_lat = 17;
`ifdef IQ_TO_PHASE_MAG_EN
  localparam bit c_mag_en = 1'b1;
`else
  localparam bit c_mag_en = 1'b0;
`endif

  typedef struct {
    int phase;
    int ptol;
    int mag;
    int mtol;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] s_axis_in_tdata;
  logic        s_axis_in_tvalid;
  logic [15:0] m_axis_phase_tdata;
  logic        m_axis_phase_tvalid;
  logic [16:0] m_axis_mag_tdata;
  logic        m_axis_mag_tvalid;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  phase_t obs_phase;

  // Directed vectors: I, Q, phase, phase tol, magnitude, magnitude tol
  int vec_i  [10] = '{32767, 0,     -32767, 0,      -32768, 0, 23170, 32767, -32767, 16384};
  int vec_q  [10] = '{0,     32767, 0,      -32767, -32768, 0, 23170, -300,  1,      -28378};
  int vec_ph [10] = '{0,     16384, 32768,  49152,  40960,  0, 8192,  65440, 32768,  54613};
  int vec_pt [10] = '{2,     2,     2,      2,      2,      0, 2,     2,     2,      2};
  int vec_mg [10] = '{32767, 32767, 32767,  32767,  46341,  0, 32768, 32768, 32767,  32768};
  int vec_mt [10] = '{2,     2,     2,      2,      3,      0, 3,     3,     2,      3};
  int pat    [7]  = '{1, 1, 0, 1, 0, 0, 1};

  iq_to_phase u_dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .s_axis_in_tdata     (s_axis_in_tdata),
    .s_axis_in_tvalid    (s_axis_in_tvalid),
    .m_axis_phase_tdata  (m_axis_phase_tdata),
    .m_axis_phase_tvalid (m_axis_phase_tvalid),
    .m_axis_mag_tdata    (m_axis_mag_tdata),
    .m_axis_mag_tvalid   (m_axis_mag_tvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Circular distance so that phase 65535 is within tolerance of 0.
  task automatic check(input string tag, input int obs, input int exp, input int tol, input int modulus);
    int d;
    checks++;
    d = obs - exp;
    d = ((d % modulus) + modulus) % modulus;
    if (modulus - d < d) d = modulus - d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
    end
  endtask

  task automatic drive(input bit v, input int i, input int q, input int ph, input int pt,
                       input int mg, input int mt);
    exp_t e;
    @(posedge clk);
    #1;
    s_axis_in_tvalid = v;
    s_axis_in_tdata  = {16'(q), 16'(i)};
    if (v) begin
      e.phase = ph;
      e.ptol  = pt;
      e.mag   = c_mag_en ? mg : 0;
      e.mtol  = c_mag_en ? mt : 0;
      e.cyc   = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_vec(input bit v, input int k);
    drive(v, vec_i[k], vec_q[k], vec_ph[k], vec_pt[k], vec_mg[k], vec_mt[k]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && m_axis_phase_tvalid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", int'(m_axis_phase_tvalid), 0, 0, 2);
      end else begin
        mon_e     = exp_q.pop_front();
        obs_phase = m_axis_phase_tdata;
        check("phase", int'(obs_phase), mon_e.phase, mon_e.ptol, 1 << DDS_PHASE_DW);
        check("latency", cyc - mon_e.cyc, c_lat, 0, 1 << 20);
        check("mag", int'(m_axis_mag_tdata), mon_e.mag, mon_e.mtol, 1 << 17);
        check("mag_valid", int'(m_axis_mag_tvalid), c_mag_en ? 1 : 0, 0, 2);
      end
    end
  end

  initial begin
    real ang;
    int  si;
    int  sq;
    reset_n          = 1'b0;
    s_axis_in_tvalid = 1'b0;
    s_axis_in_tdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_phase", int'(m_axis_phase_tdata), 0, 0, 1 << 16);
    check("rst_valid", int'(m_axis_phase_tvalid), 0, 0, 2);
    check("rst_mag", int'(m_axis_mag_tdata), 0, 0, 1 << 17);
    check("rst_mag_valid", int'(m_axis_mag_tvalid), 0, 0, 2);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    for (int k = 0; k < 10; k++) drive_vec(1'b1, k);
    idle(20);

    for (int k = 0; k < 7; k++) drive_vec(pat[k] == 1, k);
    idle(20);

    // Loopback against an ideal 16-bit DDS, back-to-back
    for (int p = 0; p < 65536; p += 7) begin
      ang = 2.0 * 3.14159265358979323846 * real'(p) / 65536.0;
      si  = $rtoi($floor(32767.0 * $cos(ang) + 0.5));
      sq  = $rtoi($floor(32767.0 * $sin(ang) + 0.5));
      drive(1'b1, si, sq, p, 4, 32767, 3);
    end
    idle(20);

    // Ten samples in flight, then a one-cycle reset pulse
    for (int k = 0; k < 10; k++) drive_vec(1'b1, k);
    @(posedge clk);
    #1;
    reset_n          = 1'b0;
    s_axis_in_tvalid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_vec(1'b1, 9);
    idle(25);

    check("drained", exp_q.size(), 0, 0, 1 << 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
